// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared types and constants for the four-digit seven-segment scan controller.
//   scan_state_e   : scan sequencer states (OFF, BLANK, DRIVE)
//   ANODE_OFF      : active-low anode pattern with every digit dark
//   NUM_DIGITS     : number of multiplexed digits
//   bcd_digit_t    : one BCD nibble
//   digit_bank_t   : packed bank of NUM_DIGITS nibbles, index 0 = ones
//   anode_onehot_n : active-low one-hot anode pattern for a digit select
// -----------------------------------------------------------------------------
package sseg_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [3:0] ANODE_OFF  = 4'hF;
    localparam int         NUM_DIGITS = 4;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [NUM_DIGITS-1:0] digit_bank_t;

    function automatic logic [3:0] anode_onehot_n(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/sseg_scan_controller_if.sv
// -----------------------------------------------------------------------------
// sseg_scan_controller_if
// Valid/ready load port carrying a new set of four BCD digits.
//   load_valid  : producer has a digit set on load_digits
//   load_ready  : controller's shadow buffer is free
//   load_digits : [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands
// Modports: master = value producer, slave = scan controller.
// -----------------------------------------------------------------------------
interface sseg_scan_controller_if;
    import sseg_pkg::*;

    logic                      load_valid;
    logic                      load_ready;
    logic [NUM_DIGITS*4-1:0]   load_digits;

    modport master (
        output load_valid,
        output load_digits,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_digits,
        output load_ready
    );

endinterface

// File: rtl/sseg_scan_timer.sv
// -----------------------------------------------------------------------------
// sseg_scan_timer
// Up-counter with synchronous clear and a terminal-count flag. The counter runs
// 0..limit-1; the owner clears it whenever it changes phase, so it never needs
// to wrap on its own.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear to 0 (takes priority over counting)
//   limit  : phase length in cycles, sampled every cycle
//   tc     : high while the count equals limit-1
// -----------------------------------------------------------------------------
module sseg_scan_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/sseg_scan_controller.sv
// -----------------------------------------------------------------------------
// sseg_scan_controller
// Time-multiplexing sequencer for a four-digit seven-segment display. Steps a
// digit select through 0..3, drives one active-low anode per digit with an
// optional all-dark gap before each digit, suppresses leading zeros on request,
// and double-buffers the displayed digits so updates land on frame boundaries.
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   enable         : 1 = scan, 0 = all anodes dark
//   lz_blank       : 1 = leading zeros stay dark (digit1 always shown)
//   load_if        : valid/ready digit load port (slave side)
//   digit1..digit4 : committed digits, ones..thousands
//   refreshcounter : digit select for the BCD mux, 0 = rightmost
//   anode_n        : active-low anode enables, bit k = digit k+1
//   frame_done     : one-cycle pulse when refreshcounter wraps 3->0
// -----------------------------------------------------------------------------
module sseg_scan_controller
    import sseg_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000,
    parameter int CNT_W           = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         lz_blank,
    sseg_scan_controller_if.slave        load_if,
    output logic [3:0]                   digit1,
    output logic [3:0]                   digit2,
    output logic [3:0]                   digit3,
    output logic [3:0]                   digit4,
    output logic [1:0]                   refreshcounter,
    output logic [3:0]                   anode_n,
    output logic                         frame_done
);

    localparam logic [CNT_W-1:0] DRIVE_LIMIT = CNT_W'(TICKS_PER_DIGIT);
    localparam logic [CNT_W-1:0] BLANK_LIMIT = CNT_W'(BLANK_TICKS);
    // With no blanking the sequencer chains DRIVE straight into DRIVE.
    localparam scan_state_e GAP_STATE = (BLANK_TICKS == 0) ? DRIVE : BLANK;

    scan_state_e      state_q, state_d;
    logic [1:0]       rc_q, rc_d;
    logic [3:0]       anode_n_q, anode_n_d;
    logic             frame_done_q, frame_done_d;
    logic             load_ready_q, load_ready_d;
    digit_bank_t      digits_q, digits_d;
    digit_bank_t      shadow_q, shadow_d;

    logic             timer_clr;
    logic             timer_tc;
    logic [CNT_W-1:0] timer_limit;
    logic             accept;
    logic             commit;

    // A digit is visible unless lz suppression is on and it, together with
    // every more significant digit, is zero. Non-BCD nibbles count as nonzero.
    function automatic logic digit_visible(input digit_bank_t bank,
                                           input logic [1:0]  sel,
                                           input logic        lz);
        logic visible;
        visible = ~lz || (sel == 2'd0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(sel)) && (bank[k] != 4'd0)) begin
                visible = 1'b1;
            end
        end
        return visible;
    endfunction

    assign timer_limit = (state_q == BLANK) ? BLANK_LIMIT : DRIVE_LIMIT;

    sseg_scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .limit (timer_limit),
        .tc    (timer_tc)
    );

    // Sequencer: next state, digit select, timer clear and wrap pulse.
    always_comb begin
        state_d      = state_q;
        rc_d         = rc_q;
        timer_clr    = 1'b0;
        frame_done_d = 1'b0;
        if (!enable) begin
            state_d   = OFF;
            rc_d      = 2'd0;
            timer_clr = 1'b1;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d   = GAP_STATE;
                    rc_d      = 2'd0;
                    timer_clr = 1'b1;
                end
                BLANK: begin
                    if (timer_tc) begin
                        state_d   = DRIVE;
                        timer_clr = 1'b1;
                    end
                end
                DRIVE: begin
                    if (timer_tc) begin
                        state_d      = GAP_STATE;
                        rc_d         = rc_q + 2'd1;
                        timer_clr    = 1'b1;
                        frame_done_d = (rc_q == 2'd3);
                    end
                end
                default: begin
                    state_d   = OFF;
                    rc_d      = 2'd0;
                    timer_clr = 1'b1;
                end
            endcase
        end
    end

    // Shadow buffer: accept needs an empty shadow and commit needs a full one,
    // so the two can never fire on the same edge.
    always_comb begin
        accept       = load_if.load_valid && load_ready_q;
        commit       = !load_ready_q && (frame_done_d || (state_q == OFF));
        shadow_d     = shadow_q;
        digits_d     = digits_q;
        load_ready_d = load_ready_q;
        if (accept) begin
            shadow_d     = digit_bank_t'(load_if.load_digits);
            load_ready_d = 1'b0;
        end
        if (commit) begin
            digits_d     = shadow_q;
            load_ready_d = 1'b1;
        end
    end

    // Anodes are decoded from the next state so they line up with state_q.
    always_comb begin
        anode_n_d = ANODE_OFF;
        if ((state_d == DRIVE) && digit_visible(digits_d, rc_d, lz_blank)) begin
            anode_n_d = anode_onehot_n(rc_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            rc_q         <= 2'd0;
            anode_n_q    <= ANODE_OFF;
            frame_done_q <= 1'b0;
            load_ready_q <= 1'b1;
            digits_q     <= '0;
            shadow_q     <= '0;
        end else begin
            state_q      <= state_d;
            rc_q         <= rc_d;
            anode_n_q    <= anode_n_d;
            frame_done_q <= frame_done_d;
            load_ready_q <= load_ready_d;
            digits_q     <= digits_d;
            shadow_q     <= shadow_d;
        end
    end

    assign digit1             = digits_q[0];
    assign digit2             = digits_q[1];
    assign digit3             = digits_q[2];
    assign digit4             = digits_q[3];
    assign refreshcounter     = rc_q;
    assign anode_n            = anode_n_q;
    assign frame_done         = frame_done_q;
    assign load_if.load_ready = load_ready_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_controller
// Two controllers share one stimulus stream: instance 0 with one blanking cycle
// per digit, instance 1 with no blanking. A reference model describes each
// display purely in terms of elapsed scan time since enable and the frame
// period, predicts the outputs for every clock, and queues them; a monitor
// compares the queued predictions with the DUT outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_sseg_scan_controller;

    localparam int TPD   = 4;
    localparam int CNT_W = 4;
    localparam int BL0   = 1;
    localparam int BL1   = 0;

    typedef struct packed {
        logic [3:0]  an;
        logic [1:0]  rc;
        logic        fd;
        logic        rdy;
        logic [15:0] dig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        lz_blank = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_digits = 16'h0;

    logic [3:0]  dig_o [2][4];
    logic [1:0]  rc_o  [2];
    logic [3:0]  an_o  [2];
    logic        fd_o  [2];

    sseg_scan_controller_if if0 ();
    sseg_scan_controller_if if1 ();

    assign if0.load_valid  = load_valid;
    assign if0.load_digits = load_digits;
    assign if1.load_valid  = load_valid;
    assign if1.load_digits = load_digits;

    sseg_scan_controller #(.TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BL0), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank), .load_if(if0),
        .digit1(dig_o[0][0]), .digit2(dig_o[0][1]), .digit3(dig_o[0][2]), .digit4(dig_o[0][3]),
        .refreshcounter(rc_o[0]), .anode_n(an_o[0]), .frame_done(fd_o[0]));

    sseg_scan_controller #(.TICKS_PER_DIGIT(TPD), .BLANK_TICKS(BL1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .lz_blank(lz_blank), .load_if(if1),
        .digit1(dig_o[1][0]), .digit2(dig_o[1][1]), .digit3(dig_o[1][2]), .digit4(dig_o[1][3]),
        .refreshcounter(rc_o[1]), .anode_n(an_o[1]), .frame_done(fd_o[1]));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Model state: scan time since enable (-1 = off), committed digits,
    // shadow contents and whether the shadow holds a pending value.
    int          run_m  [2];
    logic [15:0] dig_m  [2];
    logic [15:0] sh_m   [2];
    bit          pend_m [2];

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int i, output exp_t e);
        int   blank, period, hi;
        bit   was_off, acc, fd, driving, shown;
        logic [1:0] sel;
        blank  = (i == 0) ? BL0 : BL1;
        period = TPD + blank;
        if (!rst_n) begin
            run_m[i]  = -1;
            dig_m[i]  = 16'h0;
            sh_m[i]   = 16'h0;
            pend_m[i] = 1'b0;
            e = '{an: 4'hF, rc: 2'd0, fd: 1'b0, rdy: 1'b1, dig: 16'h0};
            return;
        end
        was_off = (run_m[i] < 0);
        acc     = load_valid && !pend_m[i];
        if (!enable)            run_m[i] = -1;
        else if (run_m[i] < 0)  run_m[i] = 0;
        else                    run_m[i] = run_m[i] + 1;
        fd = (run_m[i] > 0) && (run_m[i] % (4 * period) == 0);
        if (pend_m[i] && (was_off || fd)) begin
            dig_m[i]  = sh_m[i];
            pend_m[i] = 1'b0;
        end
        if (acc) begin
            sh_m[i]   = load_digits;
            pend_m[i] = 1'b1;
        end
        sel     = (run_m[i] < 0) ? 2'd0 : 2'((run_m[i] / period) % 4);
        driving = (run_m[i] >= 0) && ((run_m[i] % period) >= blank);
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            if (((dig_m[i] >> (4 * k)) & 16'hF) != 16'h0) hi = k;
        end
        shown  = !lz_blank || (int'(sel) <= hi);
        e.an   = (driving && shown) ? ~(4'b0001 << sel) : 4'hF;
        e.rc   = sel;
        e.fd   = fd;
        e.rdy  = !pend_m[i];
        e.dig  = dig_m[i];
    endtask

    // Prediction process: one expected output set per instance per clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0, e);
            q0.push_back(e);
            model_step(1, e);
            q1.push_back(e);
        end
    end

    // Monitor: compare predictions with the DUT away from the rising edge.
    initial begin
        exp_t e;
        logic        rdy;
        logic [15:0] dg;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    if (q0.size() == 0) continue;
                    e   = q0.pop_front();
                    rdy = if0.load_ready;
                end else begin
                    if (q1.size() == 0) continue;
                    e   = q1.pop_front();
                    rdy = if1.load_ready;
                end
                dg = {dig_o[i][3], dig_o[i][2], dig_o[i][1], dig_o[i][0]};
                chk("anode_n", i, 32'(an_o[i]), 32'(e.an));
                chk("refreshcounter", i, 32'(rc_o[i]), 32'(e.rc));
                chk("frame_done", i, 32'(fd_o[i]), 32'(e.fd));
                chk("load_ready", i, 32'(rdy), 32'(e.rdy));
                chk("digits", i, 32'(dg), 32'(e.dig));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Hold a load on the port until instance 0 takes it (bounded).
    task automatic do_load(input logic [15:0] v);
        int   n;
        logic r;
        n = 0;
        load_valid  = 1'b1;
        load_digits = v;
        forever begin
            r = if0.load_ready;
            step(1);
            if (r) break;
            n++;
            if (n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL load_timeout dut0: load_ready stayed %0d, expected 1", if0.load_ready);
                break;
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic check_reset_now();
        for (int i = 0; i < 2; i++) begin
            chk("rst_anode_n", i, 32'(an_o[i]), 32'h0000_000F);
            chk("rst_refreshcounter", i, 32'(rc_o[i]), 32'h0);
            chk("rst_frame_done", i, 32'(fd_o[i]), 32'h0);
            chk("rst_digits", i, 32'({dig_o[i][3], dig_o[i][2], dig_o[i][1], dig_o[i][0]}), 32'h0);
        end
        chk("rst_load_ready", 0, 32'(if0.load_ready), 32'h1);
        chk("rst_load_ready", 1, 32'(if1.load_ready), 32'h1);
    endtask

    initial begin
        int n;
        logic [15:0] v;

        // Power-on reset.
        step(3);
        check_reset_now();
        rst_n = 1'b1;
        step(2);

        // Basic scan with a 1234 load.
        enable = 1'b1;
        do_load(16'h1234);
        step(60);

        // Leading-zero suppression, then restored.
        lz_blank = 1'b1;
        do_load(16'h0007);
        step(50);
        lz_blank = 1'b0;
        step(30);

        // Non-BCD nibble counts as nonzero.
        lz_blank = 1'b1;
        do_load(16'h0A05);
        step(50);
        lz_blank = 1'b0;

        // Back-to-back loads: second stalls until the first commits.
        do_load(16'h1111);
        do_load(16'h2222);
        step(60);

        // Drop enable while instance 0 drives digit 3 with a load pending.
        do_load(16'h5678);
        n = 0;
        while (!(rc_o[0] == 2'd2 && an_o[0] == 4'hB)) begin
            step(1);
            n++;
            if (n > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_digit3 dut0: anode_n %h, expected B", an_o[0]);
                break;
            end
        end
        do_load(16'h9abc);
        enable = 1'b0;
        step(5);
        enable = 1'b1;
        step(40);

        // Randomised operation.
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 39) == 0)                   enable = 1'b0;
            else if (!enable && $urandom_range(0, 2) == 0)    enable = 1'b1;
            if ($urandom_range(0, 29) == 0)                   lz_blank = ~lz_blank;
            load_valid = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) begin
                v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            load_digits = v;
            step(1);
        end
        load_valid = 1'b0;
        enable     = 1'b1;
        step(10);

        // Asynchronous reset mid-frame with a load pending.
        do_load(16'h4321);
        step(3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_now();
        step(2);
        rst_n = 1'b1;
        step(40);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
